// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam int unsigned WDT_ENC_W  = 4;
  localparam int unsigned IFU_WORD_W = 32;

  // One-hot width-op encodings; fetches always use the 32-bit one.
  localparam logic [WDT_ENC_W-1:0] WDT8  = 4'b0001;
  localparam logic [WDT_ENC_W-1:0] WDT16 = 4'b0010;
  localparam logic [WDT_ENC_W-1:0] WDT32 = 4'b0100;
  localparam logic [WDT_ENC_W-1:0] WDT64 = 4'b1000;

  // One-hot grant vectors from the pick logic.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;

endpackage

// File: rtl/mem_arb_if.sv
// Request/response and memory-port signals between IFU, LSU, arbiter and memory.
interface mem_arb_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned WDT_W  = 4
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [WDT_W-1:0]  lsu_wdt_op;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ren;
  logic              mem_wen;
  logic [WDT_W-1:0]  mem_wdt_op;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wdt_op,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_raddr, mem_waddr, mem_wdata, mem_ren, mem_wen, mem_wdt_op
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wdt_op,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_raddr, mem_waddr, mem_wdata, mem_ren, mem_wen, mem_wdt_op
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational requester pick producing a one-hot grant.
// MEM_ARB_RR_EN: alternate on contention using the last-grant input; otherwise LSU first.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  req_id_e    last_grant,
`endif
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = GNT_NONE;
    if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
      grant_c = (last_grant == REQ_IFU) ? GNT_LSU : GNT_IFU;
`else
      grant_c = GNT_LSU;
`endif
    end else if (lsu_valid) begin
      grant_c = GNT_LSU;
    end else if (ifu_valid) begin
      grant_c = GNT_IFU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between IFU fetches and LSU loads/stores, one access at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned WDT_W       = 4,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e            state_q, state_d;
  req_id_e           id_q, id_d;
  logic              wen_q, wen_d;
  logic              hi_q, hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [WDT_W-1:0]  mem_wdt_q, mem_wdt_d;
  logic              ifu_resp_q, ifu_resp_d;
  logic              lsu_resp_q, lsu_resp_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;

  logic [1:0]            grant_c;
  logic                  ifu_ready_c, lsu_ready_c;
  logic [IFU_WORD_W-1:0] ifu_word_c;

`ifdef MEM_ARB_RR_EN
  req_id_e last_q, last_d;
`endif

  mem_arb_pick u_pick (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_q),
`endif
    .grant_c    (grant_c)
  );

  // Ready only in IDLE and never while reset is held.
  assign ifu_ready_c = (state_q == IDLE) && !rst && grant_c[0];
  assign lsu_ready_c = (state_q == IDLE) && !rst && grant_c[1];

  // Fetches return the 32-bit half of the memory word selected by address bit 2.
  assign ifu_word_c = hi_q ? bus.mem_rdata[2*IFU_WORD_W-1 -: IFU_WORD_W]
                           : bus.mem_rdata[IFU_WORD_W-1:0];

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    wen_d       = wen_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    mem_raddr_d = mem_raddr_q;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wdt_d   = mem_wdt_q;
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    ifu_resp_d  = 1'b0;
    lsu_resp_d  = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        // The mem_* registers double as the latched request for the rest of the access.
        if (lsu_ready_c && bus.lsu_req_valid) begin
          state_d     = ISSUE;
          id_d        = REQ_LSU;
          wen_d       = bus.lsu_wen;
          mem_ren_d   = !bus.lsu_wen;
          mem_wen_d   = bus.lsu_wen;
          mem_raddr_d = bus.lsu_wen ? '0 : bus.lsu_addr;
          mem_waddr_d = bus.lsu_wen ? bus.lsu_addr : '0;
          mem_wdata_d = bus.lsu_wen ? bus.lsu_wdata : '0;
          mem_wdt_d   = bus.lsu_wdt_op;
`ifdef MEM_ARB_RR_EN
          last_d      = REQ_LSU;
`endif
        end else if (ifu_ready_c && bus.ifu_req_valid) begin
          state_d     = ISSUE;
          id_d        = REQ_IFU;
          wen_d       = 1'b0;
          hi_d        = bus.ifu_addr[2];
          mem_ren_d   = 1'b1;
          mem_raddr_d = bus.ifu_addr;
          mem_waddr_d = '0;
          mem_wdata_d = '0;
          mem_wdt_d   = WDT_W'(WDT32);
`ifdef MEM_ARB_RR_EN
          last_d      = REQ_IFU;
`endif
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // Address and width stay on the port until capture; the memory decodes them live.
        if (cnt_q == '0) begin
          state_d     = RESP;
          mem_raddr_d = '0;
          mem_waddr_d = '0;
          mem_wdata_d = '0;
          mem_wdt_d   = '0;
          if (id_q == REQ_IFU) begin
            ifu_resp_d  = 1'b1;
            ifu_rdata_d = DATA_W'(ifu_word_c);
          end else begin
            lsu_resp_d  = 1'b1;
            lsu_rdata_d = wen_q ? '0 : bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= REQ_IFU;
      wen_q       <= 1'b0;
      hi_q        <= 1'b0;
      cnt_q       <= '0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_wdt_q   <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= REQ_IFU;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      wen_q       <= wen_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      mem_raddr_q <= mem_raddr_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdt_q   <= mem_wdt_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.ifu_req_ready  = ifu_ready_c;
  assign bus.lsu_req_ready  = lsu_ready_c;
  assign bus.ifu_resp_valid = ifu_resp_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_resp_valid = lsu_resp_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.mem_raddr      = mem_raddr_q;
  assign bus.mem_waddr      = mem_waddr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_ren        = mem_ren_q;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.mem_wdt_op     = mem_wdt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level timing model plus directed and random traffic.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned WDT_W  = 4;
  localparam int          LAT    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDT_W(WDT_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDT_W(WDT_W), .MEM_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory: returns the aligned 64-bit word for whatever read address is presented.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] al;
    al = {a[63:3], 3'b000};
    if (al == 64'h0000_0000_8000_0000) return 64'h1234_5678_0000_0013;
    return {al[31:0] ^ 32'h5A5A_C3C3, ~al[31:0]};
  endfunction
  assign bus.mem_rdata = mem_word(bus.mem_raddr);

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: at most one transaction, described by its handshake cycle.
  bit          busy;
  int          hs_cyc;
  bit          m_lsu, m_wen;
  logic [63:0] m_addr, m_wdata;
  logic [3:0]  m_wdt;
  logic [63:0] e_ifu_rdata, e_lsu_rdata;
  bit          last_lsu;
  bit          hs_ifu, hs_lsu;
  bit          dut_hs_ifu, dut_hs_lsu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ifu_req_ready"},  64'(bus.ifu_req_ready), 64'd0);
    chk({tag, ".lsu_req_ready"},  64'(bus.lsu_req_ready), 64'd0);
    chk({tag, ".ifu_resp_valid"}, 64'(bus.ifu_resp_valid), 64'd0);
    chk({tag, ".lsu_resp_valid"}, 64'(bus.lsu_resp_valid), 64'd0);
    chk({tag, ".ifu_rdata"},      bus.ifu_rdata, 64'd0);
    chk({tag, ".lsu_rdata"},      bus.lsu_rdata, 64'd0);
    chk({tag, ".mem_raddr"},      bus.mem_raddr, 64'd0);
    chk({tag, ".mem_waddr"},      bus.mem_waddr, 64'd0);
    chk({tag, ".mem_wdata"},      bus.mem_wdata, 64'd0);
    chk({tag, ".mem_ren"},        64'(bus.mem_ren), 64'd0);
    chk({tag, ".mem_wen"},        64'(bus.mem_wen), 64'd0);
    chk({tag, ".mem_wdt_op"},     64'(bus.mem_wdt_op), 64'd0);
  endtask

  task automatic model_reset();
    busy = 0; hs_cyc = 0; e_ifu_rdata = '0; e_lsu_rdata = '0; last_lsu = 0;
  endtask

  // Evaluate one cycle mid-period: predict outputs, compare, then apply this cycle's handshake.
  task automatic model_cycle();
    int rel;
    bit gi, gl, in_wait;
    logic e_ren, e_wen, e_irv, e_lrv;
    logic [63:0] e_raddr, e_waddr, e_wdata, w;
    logic [3:0] e_wdt;
    hs_ifu = 0; hs_lsu = 0;
    dut_hs_ifu = bus.ifu_req_ready && bus.ifu_req_valid;
    dut_hs_lsu = bus.lsu_req_ready && bus.lsu_req_valid;
    rel = cyc - hs_cyc;
    if (busy && rel >= LAT + 3) busy = 0;
    gi = 0; gl = 0;
    if (!busy) begin
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
        if (last_lsu) gi = 1; else gl = 1;
`else
        gl = 1;
`endif
      end else if (bus.lsu_req_valid) gl = 1;
      else if (bus.ifu_req_valid) gi = 1;
    end
    e_ren = 0; e_wen = 0; e_irv = 0; e_lrv = 0; in_wait = 0;
    e_raddr = '0; e_waddr = '0; e_wdata = '0; e_wdt = '0;
    if (busy) begin
      if (rel == 1) begin
        e_ren = !m_wen; e_wen = m_wen; e_wdt = m_wdt;
        e_raddr = m_wen ? 64'd0 : m_addr;
        e_waddr = m_wen ? m_addr : 64'd0;
        e_wdata = m_wen ? m_wdata : 64'd0;
      end else if (rel <= LAT + 1) begin
        in_wait = 1; e_wdt = m_wdt;
        e_raddr = m_wen ? 64'd0 : m_addr;
      end else begin
        w = mem_word(m_addr);
        if (m_lsu) begin
          e_lrv = 1; e_lsu_rdata = m_wen ? 64'd0 : w;
        end else begin
          e_irv = 1; e_ifu_rdata = {32'd0, m_addr[2] ? w[63:32] : w[31:0]};
        end
      end
    end
    chk("ifu_req_ready",  64'(bus.ifu_req_ready),  64'(gi));
    chk("lsu_req_ready",  64'(bus.lsu_req_ready),  64'(gl));
    chk("ifu_resp_valid", 64'(bus.ifu_resp_valid), 64'(e_irv));
    chk("lsu_resp_valid", 64'(bus.lsu_resp_valid), 64'(e_lrv));
    chk("ifu_rdata",      bus.ifu_rdata, e_ifu_rdata);
    chk("lsu_rdata",      bus.lsu_rdata, e_lsu_rdata);
    chk("mem_ren",        64'(bus.mem_ren), 64'(e_ren));
    chk("mem_wen",        64'(bus.mem_wen), 64'(e_wen));
    chk("mem_raddr",      bus.mem_raddr, e_raddr);
    chk("mem_wdt_op",     64'(bus.mem_wdt_op), 64'(e_wdt));
    if (!in_wait) begin
      chk("mem_waddr", bus.mem_waddr, e_waddr);
      chk("mem_wdata", bus.mem_wdata, e_wdata);
    end
    if (gl) begin
      hs_lsu = 1; busy = 1; hs_cyc = cyc; m_lsu = 1; last_lsu = 1;
      m_wen = bus.lsu_wen; m_addr = bus.lsu_addr; m_wdata = bus.lsu_wdata; m_wdt = bus.lsu_wdt_op;
    end else if (gi) begin
      hs_ifu = 1; busy = 1; hs_cyc = cyc; m_lsu = 0; last_lsu = 0;
      m_wen = 0; m_addr = bus.ifu_addr; m_wdata = '0; m_wdt = WDT32;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_hs(input bit want_lsu, output int hs_at);
    hs_at = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (want_lsu ? hs_lsu : hs_ifu) begin
        hs_at = cyc - 1;
        break;
      end
    end
    if (hs_at < 0) begin
      checks++; failures++;
      $display("FAIL hs_timeout cyc=%0d actual=none required=handshake", cyc);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    return 64'h8000_0000 + 64'($urandom_range(0, 511)) * 64'd4;
  endfunction

  function automatic logic [3:0] rand_wdt();
    case ($urandom_range(0, 3))
      0: return WDT8;
      1: return WDT16;
      2: return WDT32;
      default: return WDT64;
    endcase
  endfunction

  initial begin
    int c0, hs_at, n_grants;
    bit winners[4];
    bit exp_win[4];

    rst = 1'b1;
    bus.ifu_req_valid = 0; bus.ifu_addr = '0;
    bus.lsu_req_valid = 0; bus.lsu_addr = '0; bus.lsu_wen = 0; bus.lsu_wdata = '0; bus.lsu_wdt_op = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Contention on the first cycle: LSU load first, IFU at the next IDLE.
    bus.lsu_req_valid = 1; bus.lsu_wen = 0; bus.lsu_addr = 64'h8000_0008; bus.lsu_wdt_op = WDT64;
    bus.ifu_req_valid = 1; bus.ifu_addr = 64'h8000_0010;
    #1;
    chk("both.lsu_ready_c0", 64'(bus.lsu_req_ready), 64'd1);
    chk("both.ifu_ready_c0", 64'(bus.ifu_req_ready), 64'd0);
    c0 = cyc;
    step();
    bus.lsu_req_valid = 0;
    wait_hs(1'b0, hs_at);
    chk("both.ifu_grant_cycle", 64'(hs_at - c0), 64'(LAT + 3));
    bus.ifu_req_valid = 0;
    repeat (LAT + 3) step();

    // Four rounds of held contention.
    bus.lsu_req_valid = 1; bus.lsu_wen = 0; bus.lsu_addr = 64'h8000_0040; bus.lsu_wdt_op = WDT64;
    bus.ifu_req_valid = 1; bus.ifu_addr = 64'h8000_0044;
    n_grants = 0;
    for (int k = 0; k < 40 && n_grants < 4; k++) begin
      step();
      if (dut_hs_lsu || dut_hs_ifu) begin
        winners[n_grants] = dut_hs_lsu;
        n_grants++;
      end
    end
`ifdef MEM_ARB_RR_EN
    exp_win = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_win = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    chk("rounds.count", 64'(n_grants), 64'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("rounds.lsu_won[%0d]", k), 64'(winners[k]), 64'(exp_win[k]));
    bus.lsu_req_valid = 0; bus.ifu_req_valid = 0;
    repeat (LAT + 3) step();

    // IFU-only fetch of the upper half of a known word.
    bus.ifu_req_valid = 1; bus.ifu_addr = 64'h8000_0004;
    #1;
    chk("fetch.ready_c0", 64'(bus.ifu_req_ready), 64'd1);
    step();
    bus.ifu_req_valid = 0;
    chk("fetch.ren_c1", 64'(bus.mem_ren), 64'd1);
    chk("fetch.raddr_c1", bus.mem_raddr, 64'h8000_0004);
    step();
    chk("fetch.ren_c2", 64'(bus.mem_ren), 64'd0);
    chk("fetch.raddr_c2", bus.mem_raddr, 64'h8000_0004);
    repeat (LAT) step();
    chk("fetch.resp_valid", 64'(bus.ifu_resp_valid), 64'd1);
    chk("fetch.rdata", bus.ifu_rdata, 64'h0000_0000_1234_5678);
    step();
    chk("fetch.resp_pulse_end", 64'(bus.ifu_resp_valid), 64'd0);
    chk("fetch.rdata_held", bus.ifu_rdata, 64'h0000_0000_1234_5678);
    repeat (2) step();

    // 32-bit store.
    bus.lsu_req_valid = 1; bus.lsu_wen = 1; bus.lsu_addr = 64'h8000_1000;
    bus.lsu_wdata = 64'h0000_0000_DEAD_BEEF; bus.lsu_wdt_op = WDT32;
    step();
    bus.lsu_req_valid = 0; bus.lsu_wen = 0;
    chk("store.wen_c1", 64'(bus.mem_wen), 64'd1);
    chk("store.ren_c1", 64'(bus.mem_ren), 64'd0);
    chk("store.waddr_c1", bus.mem_waddr, 64'h8000_1000);
    chk("store.wdata_c1", bus.mem_wdata, 64'h0000_0000_DEAD_BEEF);
    chk("store.wdt_c1", 64'(bus.mem_wdt_op), 64'(WDT32));
    step();
    chk("store.wen_c2", 64'(bus.mem_wen), 64'd0);
    repeat (LAT) step();
    chk("store.resp_valid", 64'(bus.lsu_resp_valid), 64'd1);
    chk("store.rdata", bus.lsu_rdata, 64'd0);
    repeat (2) step();

    // Asynchronous reset in the middle of an LSU load.
    bus.lsu_req_valid = 1; bus.lsu_wen = 0; bus.lsu_addr = 64'h8000_0020; bus.lsu_wdt_op = WDT64;
    step();
    bus.lsu_req_valid = 0;
    step();
    #3;
    bus.ifu_req_valid = 1; bus.ifu_addr = 64'h8000_0004;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_held");
    rst = 1'b0;
    model_reset();
    c0 = cyc;
    step();
    chk("post_rst.hs", 64'(dut_hs_ifu), 64'd1);
    bus.ifu_req_valid = 0;
    repeat (LAT + 1) step();
    chk("post_rst.resp_cycle", 64'(cyc - c0), 64'(LAT + 2));
    chk("post_rst.resp_valid", 64'(bus.ifu_resp_valid), 64'd1);
    chk("post_rst.rdata", bus.ifu_rdata, 64'h0000_0000_1234_5678);
    chk("post_rst.no_lsu_resp", 64'(bus.lsu_resp_valid), 64'd0);
    repeat (2) step();

    // Random traffic with legal valid drops.
    for (int n = 0; n < 600; n++) begin
      step();
      if (hs_ifu || !bus.ifu_req_valid) begin
        bus.ifu_req_valid = 1'($urandom_range(0, 1));
        bus.ifu_addr = rand_addr();
      end else if ($urandom_range(0, 15) == 0) begin
        bus.ifu_req_valid = 0;
      end
      if (hs_lsu || !bus.lsu_req_valid) begin
        bus.lsu_req_valid = 1'($urandom_range(0, 1));
        bus.lsu_addr = rand_addr();
        bus.lsu_wen = 1'($urandom_range(0, 1));
        bus.lsu_wdata = {$urandom, $urandom};
        bus.lsu_wdt_op = rand_wdt();
      end else if ($urandom_range(0, 15) == 0) begin
        bus.lsu_req_valid = 0;
      end
    end
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
    repeat (LAT + 4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port (DPI pmem read/write wrapper) between instruction fetch (IFU) and load/store unit (LSU).
- Accepts one request at a time through valid/ready handshakes and sequences the memory port: issue, wait latency, capture, respond.
- Sits between the IFU/LSU and the memory module in the single-issue npc core.

Parameters:
- ADDR_W, 64, address width (matches AddrWidth)
- DATA_W, 64, data width (matches RegWidth)
- WDT_W, 4, width-op encoding width (matches WdtTypeCnt)
- MEM_LATENCY, 1, cycles after the issue cycle until mem_rdata is valid (≥1)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_rdata  out  DATA_W  fetch data (Wdt32 slice, zero-extended)
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1=store, 0=load
- lsu_wdata  in  DATA_W  store data
- lsu_wdt_op  in  WDT_W  access width
- lsu_resp_valid  out  1  one-cycle pulse, load data valid or store done
- lsu_rdata  out  DATA_W  load data (0 for stores)
- mem_raddr  out  ADDR_W  to memory
- mem_waddr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_ren  out  1  to memory
- mem_wen  out  1  to memory
- mem_wdt_op  out  WDT_W  to memory
- mem_rdata  in  DATA_W  from memory

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-high. On reset, state=IDLE and all outputs are 0 (ready, resp_valid, mem_ren, mem_wen, addresses, wdata, wdt_op, rdata).
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ready is asserted combinationally to the picked requester only.
  - Pick: LSU wins if lsu_req_valid; otherwise IFU if ifu_req_valid.
  - On handshake (valid&&ready), latch id, addr, wen, wdata and wdt_op (IFU: wen=0, wdt=Wdt32), then go to ISSUE.
- ISSUE (1 cycle):
  - Load/fetch: mem_ren=1, mem_raddr=latched addr.
  - Store: mem_wen=1, mem_waddr=latched addr, mem_wdata=latched data.
  - mem_wdt_op=latched wdt.
  - Go to WAIT with counter=MEM_LATENCY-1.
- WAIT:
  - ren/wen=0; mem_raddr and mem_wdt_op stay held, because the memory output mux decodes them live.
  - When counter==0, capture mem_rdata (stores capture 0) and go to RESP; otherwise decrement.
- RESP (1 cycle):
  - The owner's resp_valid=1 with the captured data.
  - rdata outputs hold their value until the next response. All mem_* outputs return to 0.
  - Next state is IDLE.
- Timing:
  - Handshake in cycle 0, issue in cycle 1, resp_valid in cycle 2+MEM_LATENCY (cycle 3 at default).
  - Throughput: one access per 3+MEM_LATENCY cycles.
- Handshake rules:
  - ready=0 in every non-IDLE state.
  - Requesters hold valid and payload stable until ready. Dropping valid before ready is legal and nothing is issued.
  - Response pulses have no backpressure; requesters must accept them.
- Simultaneous valid in IDLE → LSU granted; IFU keeps valid and is granted at the next IDLE.
- Reset mid-operation: the in-flight access is abandoned, no resp_valid pulse is produced, and the FSM returns to IDLE.
  - A store already in ISSUE may or may not have committed; this is not guaranteed.
- Never mem_ren and mem_wen in the same cycle. Never both ready outputs high. Never both resp_valid outputs high.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Round-robin pick using a 1-bit last-grant register (reset value = IFU, so the first contention goes to LSU).
  - On contention, the requester not granted last time wins.
  - The register updates on each handshake.
- Undefined: fixed LSU-over-IFU priority; no last-grant register.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - requester-id enum {REQ_IFU, REQ_LSU}
  - IFU width constant (Wdt32 encoding)
- Sub-module mem_arb_pick: combinational pick from both valids (plus last-grant under MEM_ARB_RR_EN), output one-hot grant; used by the IDLE logic.

Test Plan:
- IFU-only fetch addr 0x80000004, memory word 0x1234567800000013:
  - ifu_req_ready high in cycle 0; mem_ren high only in cycle 1 with raddr held through WAIT.
  - ifu_resp_valid in cycle 3 with rdata 0x12345678.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, Wdt32:
  - mem_wen=1 in cycle 1 only, wdt_op=Wdt32, mem_ren=0 throughout.
  - lsu_resp_valid in cycle 3 with lsu_rdata=0.
- Both valid in cycle 0:
  - LSU load granted first; IFU granted at cycle 4 IDLE; no overlap of ready or resp_valid.
- Back-to-back contention, 4 rounds, both held valid:
  - Default: LSU wins all 4 rounds.
  - With MEM_ARB_RR_EN: grants alternate LSU, IFU, LSU, IFU.
- rst asserted asynchronously during WAIT of an LSU load:
  - All outputs 0 immediately and no lsu_resp_valid.
  - After release, a fresh IFU fetch completes with normal 3-cycle latency.
- MEM_LATENCY=3: IFU fetch → resp_valid in cycle 5; mem_raddr stable cycles 1–4.
